flp_norm_iter: RTL
==================

FLP_NORM_ITER -- requirements
Module: flp_norm_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, mantissa width in bits.
REQ-002 SHALL have parameter EXPW, default 8, biased exponent width in bits.
REQ-003 SHALL have parameter STEP, default 8, maximum left-shift per cycle; power of two, 1..WIDTH.
REQ-004 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port i_valid, input, 1, input operand valid.
REQ-007 SHALL have port i_ready, output, 1, block can accept an operand.
REQ-008 SHALL have port i_mant, input, WIDTH, unnormalized mantissa.
REQ-009 SHALL have port i_exp, input, EXPW, unsigned biased exponent.
REQ-010 SHALL have port o_valid, output, 1, result valid.
REQ-011 SHALL have port o_ready, input, 1, consumer accepts result.
REQ-012 SHALL have port o_mant, output, WIDTH, normalized mantissa.
REQ-013 SHALL have port o_exp, output, EXPW, result exponent (0 for zero or denormal).
REQ-014 SHALL have ports o_zero and o_denorm, output, 1 each, result class flags.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, DONE; i_ready=1 only in IDLE; o_valid=1 only in DONE.
REQ-016 SHALL capture i_mant/i_exp into internal registers on i_valid&&i_ready and go IDLE->SHIFT.
REQ-017 SHALL, in SHIFT each cycle, compute L=leading-zero count of the working mantissa and shift left by k=min(L, STEP, exp-1), zero-padding LSBs, with exp reduced by k.
REQ-018 SHALL go SHIFT->DONE in the same cycle the registered result becomes terminal: MSB set, or mantissa zero, or exp reaches 1 with MSB clear.
REQ-019 SHALL spend max(1, ceil(min(L0, e0-1)/STEP)) cycles in SHIFT, where L0 and e0 are the captured values; a captured exp of 0 is treated as 1 (no shift).
REQ-020 SHALL, for a zero mantissa, output o_mant=0, o_exp=0, o_zero=1, o_denorm=0.
REQ-021 SHALL, for a nonzero result with MSB clear, output o_exp=0, o_denorm=1, o_zero=0.
REQ-022 SHALL, for a normalized result, output the reduced exponent, with o_zero=0 and o_denorm=0.
REQ-023 SHALL hold o_mant, o_exp and the flags stable in DONE until o_ready; DONE->IDLE on o_valid&&o_ready.
REQ-024 SHALL NOT accept a new operand until the cycle after the output handshake (no overlap).

Reset
REQ-025 SHALL, when rst=1 at a clock edge, enter IDLE, clear all data registers, and drive o_valid=0, o_mant=0, o_exp=0, o_zero=0, o_denorm=0, i_ready=1 from the next cycle.
REQ-026 SHALL abandon any in-flight operand on reset mid-SHIFT or mid-DONE; no stale o_valid follows.

Configuration
REQ-027 SHALL, with FLP_NORM_ITER_BYPASS_EN defined, go IDLE->DONE directly for an accepted operand whose MSB is set or whose mantissa is zero (one cycle less latency).
REQ-028 SHALL, without FLP_NORM_ITER_BYPASS_EN, route every operand through SHIFT per REQ-019.

Verification
REQ-029 SHALL cover: mant 0x80000000, exp 0x7F -> o_mant 0x80000000, o_exp 0x7F, 1 SHIFT cycle (0 with bypass).
REQ-030 SHALL cover: mant 0x00000001, exp 100 -> o_mant 0x80000000, o_exp 69, 4 SHIFT cycles.
REQ-031 SHALL cover: mant 0x00010000, exp 5 -> o_mant 0x00100000, o_exp 0, o_denorm=1, 1 SHIFT cycle.
REQ-032 SHALL cover: mant 0, exp 0x55 -> o_mant 0, o_exp 0, o_zero=1.
REQ-033 SHALL cover: o_ready held low 5 cycles in DONE -> outputs stable, i_ready=0; rst asserted mid-SHIFT -> IDLE and o_valid=0 next cycle.

Source files
------------

// File: rtl/flp_norm_iter.sv
// flp_norm_iter: iterative floating-point mantissa normalizer.
//
// Accepts an unnormalized mantissa and biased exponent. Each SHIFT cycle it
// shifts the mantissa left by up to STEP positions. The shift stops when the
// MSB is set, the mantissa is zero, or the exponent reaches 1. The result is
// classified as zero, denormal or normal.
//
// Parameters:
//   WIDTH - mantissa width in bits
//   EXPW  - biased exponent width in bits
//   STEP  - maximum left shift per cycle (power of two, 1..WIDTH)
//
// Ports:
//   clk, rst          - clock; synchronous active-high reset
//   i_valid/i_ready   - operand handshake (i_ready only in IDLE)
//   i_mant, i_exp     - operand mantissa and exponent
//   o_valid/o_ready   - result handshake (o_valid only in DONE)
//   o_mant, o_exp     - normalized mantissa and result exponent (0 for zero/denormal)
//   o_zero, o_denorm  - result class flags
//
// Optional feature: define FLP_NORM_ITER_BYPASS_EN to send operands that are
// already terminal (MSB set or zero mantissa) straight from IDLE to DONE.

module flp_norm_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned EXPW  = 8,
    parameter int unsigned STEP  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [WIDTH-1:0] i_mant,
    input  logic [EXPW-1:0]  i_exp,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [WIDTH-1:0] o_mant,
    output logic [EXPW-1:0]  o_exp,
    output logic             o_zero,
    output logic             o_denorm
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    // Common width for comparing the leading-zero count, STEP and exponent.
    localparam int unsigned KW = ((CW > EXPW) ? CW : EXPW) + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] mant_q, mant_d;
    logic [EXPW-1:0]  exp_q, exp_d;

    logic [CW-1:0]    lzc;
    logic [KW-1:0]    k;
    logic [KW-1:0]    exp_room;
    logic [WIDTH-1:0] shifted;
    logic [EXPW-1:0]  exp_dec;
    logic             terminal;
    logic [EXPW-1:0]  exp_in;
    logic             res_zero;
    logic             res_denorm;
    logic             in_done;

    // Leading-zero count; the highest set bit is the last one to update it.
    always_comb begin
        lzc = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (mant_q[i]) begin
                lzc = CW'(WIDTH - 1 - i);
            end
        end
    end

    // k = min(L, STEP, exp-1). exp_q is at least 1 whenever SHIFT uses this.
    always_comb begin
        exp_room = KW'(exp_q) - KW'(1);
        k        = KW'(lzc);
        if (KW'(STEP) < k) begin
            k = KW'(STEP);
        end
        if (exp_room < k) begin
            k = exp_room;
        end
        shifted  = mant_q << k;
        exp_dec  = exp_q - EXPW'(k);
        terminal = shifted[WIDTH-1] || (shifted == '0) || (exp_dec == EXPW'(1));
    end

    // An exponent of 0 behaves as 1: no room to shift.
    assign exp_in = (i_exp == '0) ? EXPW'(1) : i_exp;

    always_comb begin
        state_d = state_q;
        mant_d  = mant_q;
        exp_d   = exp_q;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    mant_d  = i_mant;
                    exp_d   = exp_in;
                    state_d = ST_SHIFT;
`ifdef FLP_NORM_ITER_BYPASS_EN
                    if (i_mant[WIDTH-1] || (i_mant == '0)) begin
                        state_d = ST_DONE;
                    end
`else
`endif
                end
            end
            ST_SHIFT: begin
                mant_d = shifted;
                exp_d  = exp_dec;
                if (terminal) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (o_ready) begin
                    state_d = ST_IDLE;
                    mant_d  = '0;
                    exp_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                mant_d  = '0;
                exp_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mant_q  <= '0;
            exp_q   <= '0;
        end else begin
            state_q <= state_d;
            mant_q  <= mant_d;
            exp_q   <= exp_d;
        end
    end

    assign in_done    = (state_q == ST_DONE);
    assign res_zero   = (mant_q == '0);
    assign res_denorm = !res_zero && !mant_q[WIDTH-1];

    assign i_ready  = (state_q == ST_IDLE);
    assign o_valid  = in_done;
    assign o_mant   = in_done ? mant_q : '0;
    assign o_exp    = (in_done && !res_zero && !res_denorm) ? exp_q : '0;
    assign o_zero   = in_done && res_zero;
    assign o_denorm = in_done && res_denorm;

endmodule
